// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmitter.
//   t_tx_states : transmitter frame states
//   CRC8_POLY   : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT   : CRC register value at the start of each frame
//   DATA_BITS   : payload bits per frame
//   crc8_step   : one serial CRC-8 update for a single wire bit
package uart_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE       = 3'd0,
        TX_START      = 3'd1,
        TX_DATA_BITS  = 3'd2,
        TX_PARITY_BIT = 3'd3,
        TX_CRC        = 3'd4,
        TX_STOP_BIT   = 3'd5
    } t_tx_states;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int unsigned DATA_BITS = 8;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/uart_tx_crc8.sv
// uart_tx_crc8: serial CRC-8 accumulator, one bit per enabled cycle.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (register -> CRC8_INIT)
//   clr_i  : synchronous clear to CRC8_INIT (wins over en_i)
//   en_i   : consume bit_i this cycle
//   bit_i  : serial data bit in wire order
//   crc_o  : current CRC register
module uart_tx_crc8
    import uart_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC8_INIT;
        end else if (clr_i) begin
            crc_q <= CRC8_INIT;
        end else if (en_i) begin
            crc_q <= crc8_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Frame = start bit, 8 data bits LSB-first,
// then either a parity bit or a CRC-8 trailer (MSB-first), then stop bits.
// Bit timing is driven by the external one-cycle baud pulse trigger_i.
// A single-entry holding register allows back-to-back frames.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   trigger_i : baud pulse, one cycle high per bit period
//   break_i   : (only with UART_TX_BREAK_EN) hold line low while idle
//   data_i    : byte to send
//   crc_en_i  : 1 = CRC-8 trailer, 0 = parity bit (sampled with data_i)
//   valid_i   : producer has a byte
//   ready_o   : holding register empty
//   tx_o      : serial line, idle high
//   busy_o    : frame in progress or holding register full
//   done_o    : one-cycle pulse at the end of the final stop bit
// Optional feature macro: UART_TX_BREAK_EN (adds break_i).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       trigger_i,
`ifdef UART_TX_BREAK_EN
    input  logic       break_i,
`endif
    input  logic [7:0] data_i,
    input  logic       crc_en_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    t_tx_states state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       ready_q;

    logic [7:0] hold_data_q;
    logic       hold_crc_q;
    logic       hold_full_q, hold_full_d;
    logic       frame_crc_q;
    logic       parity_q;

    logic       accept;
    logic       load;
    logic       crc_clr;
    logic       crc_step;
    logic       brk;
    logic       par_calc;
    logic [7:0] crc_q;
    logic [7:0] crc_final;
    logic [7:0] crc_shl;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    assign accept   = valid_i & ~hold_full_q;
    assign par_calc = (PARITY_ODD != 0) ? ~^hold_data_q : ^hold_data_q;

    // tx_o is a true register, so the first CRC bit has to be taken from
    // the CRC value that includes the last data bit, one step ahead.
    assign crc_final = crc8_step(crc_q, shift_q[0]);
    assign crc_shl   = crc_q << (cnt_q + 5'd1);

    uart_tx_crc8 u_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_step),
        .bit_i (shift_q[0]),
        .crc_o (crc_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        load     = 1'b0;
        crc_clr  = 1'b0;
        crc_step = 1'b0;

        case (state_q)
            TX_IDLE: begin
                // Break acts every cycle while idle; launching waits for a baud pulse.
                tx_d = ~brk;
                if (trigger_i && !brk && hold_full_q) begin
                    load    = 1'b1;
                    crc_clr = 1'b1;
                    state_d = TX_START;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (trigger_i) begin
                    state_d = TX_DATA_BITS;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA_BITS: begin
                if (trigger_i) begin
                    crc_step = 1'b1;
                    shift_d  = {1'b0, shift_q[7:1]};
                    if (cnt_q == 5'(DATA_BITS - 1)) begin
                        cnt_d = '0;
                        if (frame_crc_q) begin
                            state_d = TX_CRC;
                            tx_d    = crc_final[7];
                        end else begin
                            state_d = TX_PARITY_BIT;
                            tx_d    = parity_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            TX_PARITY_BIT: begin
                if (trigger_i) begin
                    state_d = TX_STOP_BIT;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            TX_CRC: begin
                if (trigger_i) begin
                    if (cnt_q == 5'd7) begin
                        state_d = TX_STOP_BIT;
                        cnt_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        tx_d  = crc_shl[7];
                    end
                end
            end
            TX_STOP_BIT: begin
                if (trigger_i) begin
                    if (cnt_q == 5'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            crc_clr = 1'b1;
                            state_d = TX_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = TX_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        tx_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (trigger_i) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            hold_data_q <= '0;
            hold_crc_q  <= 1'b0;
            hold_full_q <= 1'b0;
            frame_crc_q <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            if (accept) begin
                hold_data_q <= data_i;
                hold_crc_q  <= crc_en_i;
            end
            if (load) begin
                shift_q     <= hold_data_q;
                frame_crc_q <= hold_crc_q;
                parity_q    <= par_calc;
            end else begin
                shift_q <= shift_d;
            end
        end
    end

    assign tx_o    = tx_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;
    assign busy_o  = (state_q != TX_IDLE) | hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. dut1 uses even parity and one
// stop bit; dut2 uses odd parity and two stop bits (and break_i when
// UART_TX_BREAK_EN is defined). Baud pulse every 16 clocks.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tcnt = 4'd0;
    logic       trigger;

    logic [7:0] data1, data2;
    logic       crc1, crc2;
    logic       valid1, valid2;
    logic       ready1, ready2;
    logic       tx1, tx2;
    logic       busy1, busy2;
    logic       done1, done2;
`ifdef UART_TX_BREAK_EN
    logic       brk1, brk2;
`endif

    int tests = 0;
    int fails = 0;
    int dcnt1 = 0;
    int dcnt2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 4'd1;
    assign trigger = (tcnt == 4'd15);

    always @(negedge clk) begin
        if (done1 === 1'b1) dcnt1++;
        if (done2 === 1'b1) dcnt2++;
    end

    uart_tx #(.PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .trigger_i (trigger),
`ifdef UART_TX_BREAK_EN
        .break_i   (brk1),
`endif
        .data_i    (data1),
        .crc_en_i  (crc1),
        .valid_i   (valid1),
        .ready_o   (ready1),
        .tx_o      (tx1),
        .busy_o    (busy1),
        .done_o    (done1)
    );

    uart_tx #(.PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk_i     (clk),
        .rst_i     (rst),
        .trigger_i (trigger),
`ifdef UART_TX_BREAK_EN
        .break_i   (brk2),
`endif
        .data_i    (data2),
        .crc_en_i  (crc2),
        .valid_i   (valid2),
        .ready_o   (ready2),
        .tx_o      (tx2),
        .busy_o    (busy2),
        .done_o    (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int w);
        return (w == 2) ? tx2 : tx1;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 2) ? busy2 : busy1;
    endfunction

    // Expected line bits, bit i = i-th bit period starting at the start bit.
    function automatic logic [31:0] frame(input logic [7:0] d, input bit use_crc,
                                          input bit odd, input int stops);
        logic [31:0] f;
        logic [7:0]  c;
        logic        fb;
        int          n;
        f = '0;
        f[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f[n] = d[i];
            n++;
        end
        if (use_crc) begin
            c = 8'h00;
            for (int i = 0; i < 8; i++) begin
                fb = d[i] ^ c[7];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
            for (int i = 7; i >= 0; i--) begin
                f[n] = c[i];
                n++;
            end
        end else begin
            f[n] = odd ? ~^d : ^d;
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    // Returns half a clock after the next baud-pulse edge.
    task automatic next_bit();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (trigger) break;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int w);
        int k;
        for (k = 0; k < 800; k++) begin
            @(negedge clk);
            if (busy_of(w) === 1'b0) break;
        end
        if (k == 800) chk("idle_timeout", 32'(busy_of(w)), 32'd0);
    endtask

    task automatic send(input int w, input logic [7:0] d, input logic c);
        @(negedge clk);
        if (w == 2) begin
            valid2 = 1'b1; data2 = d; crc2 = c;
        end else begin
            valid1 = 1'b1; data1 = d; crc1 = c;
        end
        @(negedge clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    // Waits for a start bit, then records n bit periods and checks each
    // bit holds its value across the whole period.
    task automatic capture(input int w, input int n, output logic [31:0] bits);
        bit   found;
        int   bad;
        logic v;
        bits  = '0;
        found = 1'b0;
        bad   = 0;
        for (int i = 0; i < 40; i++) begin
            next_bit();
            if (line(w) === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("start_found", 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) next_bit();
                v = line(w);
                bits[i] = v;
                repeat (14) @(negedge clk);
                if (line(w) !== v) bad++;
            end
        end
        chk("bit_hold", 32'(bad), 32'd0);
    endtask

    logic [31:0] got;
    int          d0;

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid1 = 1'b0; data1 = 8'h00; crc1 = 1'b0;
        valid2 = 1'b0; data2 = 8'h00; crc2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk1 = 1'b0; brk2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx1), 32'd1);
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        rst = 1'b0;

        // 0xA5, even parity
        d0 = dcnt1;
        send(1, 8'hA5, 1'b0);
        chk("a5_ready_low", 32'(ready1), 32'd0);
        chk("a5_busy_hold", 32'(busy1), 32'd1);
        capture(1, 11, got);
        chk("a5_frame", got, 32'h54A);
        next_bit();
        next_bit();
        chk("a5_done_once", 32'(dcnt1 - d0), 32'd1);
        chk("a5_busy_end", 32'(busy1), 32'd0);
        chk("a5_idle_line", 32'(tx1), 32'd1);

        // 0x07: odd parity -> 0, two stop bits; even parity -> 1
        send(2, 8'h07, 1'b0);
        capture(2, 12, got);
        chk("07_odd_frame", got, 32'hC0E);
        wait_idle(1);
        send(1, 8'h07, 1'b0);
        capture(1, 11, got);
        chk("07_even_frame", got, 32'h60E);

        // CRC trailers
        wait_idle(1);
        send(1, 8'h80, 1'b1);
        capture(1, 18, got);
        chk("80_crc_frame", got, 32'h3C100);
        wait_idle(1);
        send(1, 8'h00, 1'b1);
        capture(1, 18, got);
        chk("00_crc_frame", got, 32'h20000);

        // Back-to-back 0x55 then 0xAA with valid held high
        wait_idle(1);
        d0 = dcnt1;
        @(negedge clk);
        valid1 = 1'b1; data1 = 8'h55; crc1 = 1'b0;
        @(negedge clk);
        data1 = 8'hAA;
        chk("b2b_ready_low", 32'(ready1), 32'd0);
        fork
            capture(1, 22, got);
            begin
                int k;
                for (k = 0; k < 64; k++) begin
                    @(negedge clk);
                    if (ready1 === 1'b1) break;
                end
                if (k == 64) chk("b2b_ready_timeout", 32'(ready1), 32'd1);
                @(negedge clk);
                valid1 = 1'b0;
                data1  = 8'h33;
                crc1   = 1'b1;
                chk("b2b_hold_full", 32'(ready1), 32'd0);
            end
        join
        chk("b2b_frames", got, 32'h2AA4AA);
        wait_idle(1);
        chk("b2b_done_twice", 32'(dcnt1 - d0), 32'd2);

        // Reset in the middle of the data bits
        send(1, 8'hFF, 1'b0);
        capture(1, 3, got);
        chk("pre_rst_bits", got, 32'h6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx1), 32'd1);
        chk("mid_rst_ready", 32'(ready1), 32'd1);
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        send(1, 8'h3C, 1'b1);
        capture(1, 18, got);
        chk("3c_crc_frame", got, frame(8'h3C, 1'b1, 1'b0, 1));
        wait_idle(1);
        send(1, 8'h3C, 1'b0);
        capture(1, 11, got);
        chk("3c_par_frame", got, frame(8'h3C, 1'b0, 1'b0, 1));

`ifdef UART_TX_BREAK_EN
        wait_idle(2);
        d0 = dcnt2;
        brk2 = 1'b1;
        send(2, 8'h5A, 1'b0);
        next_bit();
        next_bit();
        next_bit();
        chk("brk_line_low", 32'(tx2), 32'd0);
        chk("brk_no_launch", 32'(busy2), 32'd1);
        chk("brk_ready_low", 32'(ready2), 32'd0);
        brk2 = 1'b0;
        @(negedge clk);
        chk("brk_release", 32'(tx2), 32'd1);
        capture(2, 12, got);
        chk("5a_odd_2stop", got, frame(8'h5A, 1'b0, 1'b1, 2));
        wait_idle(2);
        chk("5a_done", 32'(dcnt2 - d0), 32'd1);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit end of the team's UART link. It serialises bytes from a valid/ready producer into frames: start bit, 8 data bits LSB-first, then either an even/odd parity bit or an 8-bit CRC-8 trailer, then stop bits. Bit timing comes from an external one-cycle baud pulse (trigger_i) shared with the receiver's timebase. A single-entry holding register allows back-to-back frames with no idle gap.

Parameters:
PARITY_ODD, 0, 0 = even parity bit, 1 = odd parity bit (used only when CRC is not selected).
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
clk_i  input  1  clock.
rst_i  input  1  synchronous active-high reset.
trigger_i  input  1  baud pulse; one cycle high per bit period.
data_i  input  8  byte to send.
crc_en_i  input  1  sampled with data_i; 1 = CRC-8 trailer, 0 = parity bit.
valid_i  input  1  producer has a byte.
ready_o  output  1  holding register empty; byte accepted when valid_i & ready_o.
tx_o  output  1  serial line, idle high.
busy_o  output  1  state != TX_IDLE or holding register full.
done_o  output  1  one-cycle pulse when the final stop bit period ends.

Behaviour:
- Reset is synchronous. It takes effect at the next clk_i edge regardless of the current state, including mid-frame, and the partial frame is abandoned. Reset values: state TX_IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, holding register empty, bit counter 0, CRC register 0x00.
- Acceptance: when valid_i & ready_o are both high at a clock edge, data_i and crc_en_i are latched into the holding register and ready_o goes low the next cycle. ready_o is the registered inverse of the hold-full flag, with no same-cycle bypass.
- All state transitions and tx_o changes occur only on cycles with trigger_i=1. tx_o is registered and changes on the edge where trigger_i is sampled high.
- States:
  - TX_IDLE: tx_o=1. On trigger_i with hold full, move the holding register into the shift register, clear hold-full, clear the CRC register, compute parity, and go to TX_START.
  - TX_START: tx_o=0 for 1 bit period. Then go to TX_DATA_BITS with bit_cnt=0.
  - TX_DATA_BITS: tx_o=shift[0]. Shift right and feed the bit to the CRC on each trigger_i. After bit_cnt==7, go to TX_CRC if the latched crc_en is 1, otherwise TX_PARITY_BIT.
  - TX_PARITY_BIT: 1 bit period. Line value is ^data for even parity, ~^data for odd. Then go to TX_STOP_BIT.
  - TX_CRC: 8 bit periods, sending crc[7] first (MSB-first). Then go to TX_STOP_BIT.
  - TX_STOP_BIT: tx_o=1 for STOP_BITS periods. At the final trigger_i, pulse done_o. If hold is full, reload and go directly to TX_START (back-to-back frames); otherwise go to TX_IDLE.
- CRC-8: polynomial 0x07, init 0x00, serial over data bits in wire order. Per bit: fb = b ^ crc[7]; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00). The value is frozen on leaving TX_DATA_BITS.
- bit_cnt is 5 bits wide. It resets to 0 on every state change and increments on trigger_i within a state.
- Boundary cases:
  - Acceptance in the same cycle as the TX_IDLE trigger: the byte is written to hold but not launched until the next trigger_i.
  - valid_i while hold is full: ignored, since ready_o=0.
  - crc_en_i and data_i changing after acceptance have no effect on the frame in flight.
- Illegal state encodings return to TX_IDLE on the next trigger_i.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input break_i (1 bit). While break_i=1 and state is TX_IDLE, tx_o is forced to 0 and no frame launches, even with hold full. Releasing break_i restores tx_o=1 on the next edge. break_i asserted mid-frame has no effect until the frame ends.
- Undefined: the port is absent and tx_o idles at 1.

Decomposition:
- uart_tx_pkg:
  - typedef enum logic [2:0] t_tx_states {TX_IDLE, TX_START, TX_DATA_BITS, TX_PARITY_BIT, TX_CRC, TX_STOP_BIT}.
  - localparams CRC8_POLY=8'h07, CRC8_INIT=8'h00, DATA_BITS=8.
- Sub-module uart_tx_crc8: serial CRC unit with ports clk_i, rst_i, clr_i, en_i, bit_i, crc_o[7:0].

Test Plan:
1. Byte 0xA5, parity, even, trigger_i every 16 cycles -> tx_o sequence 0,1,0,1,0,0,1,0,1,0,1. Each bit held 16 cycles; done_o pulses once; busy_o returns to 0.
2. Byte 0x07, parity, PARITY_ODD=1 -> parity bit 0 (three ones). Same byte with even parity -> parity bit 1.
3. Byte 0x80, crc_en_i=1 -> data bits 0,0,0,0,0,0,0,1, then CRC 0x07 sent as 0,0,0,0,0,1,1,1, then stop 1. Byte 0x00 -> CRC bits all 0.
4. Two bytes 0x55 then 0xAA with valid_i held high -> second accepted during the first frame; ready_o low until hold drains. The start bit of 0xAA follows the stop bit of 0x55 directly, with no extra idle period; done_o pulses twice.
5. Reset asserted mid TX_DATA_BITS -> next edge tx_o=1, ready_o=1, busy_o=0. A new byte 0x3C afterwards transmits correctly with fresh CRC/parity.
6. STOP_BITS=2, plus UART_TX_BREAK_EN with break_i=1 in TX_IDLE and a byte pending -> tx_o=0, no launch. After release, the frame sends with 2 stop-bit periods.
